simd_int_mul_pipe: RTL

Parametrised successor to the fixed 7-stage single-precision/multiply pipe. It is an N-lane SIMD integer multiply pipeline with configurable lane width, latency and flush depth. Unlike the previous block it adds a stall hold, a per-stage RT scoreboard for hazard detection, and an explicit output-valid. It sits in the odd/even execute cluster and emits the standard writeback packet: data, unit tag, write-enable, RT.

---
 rtl/simd_int_mul_pipe.sv | 136 +++++++++++++
 1 files changed

// File: rtl/simd_int_mul_pipe.sv
// simd_int_mul_pipe: N-lane SIMD integer multiply pipeline with stall hold, youngest-stage
// flush, per-stage RT scoreboard and an explicit output-valid. Emits the standard writeback
// packet {data, unit, we, rt}.
// Buses use MSB-first numbering: lane 0 is the most significant LANE_W field of ra/rb/rc and
// of the packet data. Within a lane, L is the numerically low halfword and H the high one.
module simd_int_mul_pipe #(
  parameter int LANES       = 4,
  parameter int LANE_W      = 32,
  parameter int LATENCY     = 7,
  parameter int RT_W        = 7,
  parameter int UNIT_ID     = 7,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           flush_i,
  input  logic                           stall_i,
  input  logic                           in_valid_i,
  input  logic [2:0]                     op_i,
  input  logic [LANES*LANE_W-1:0]        ra_i,
  input  logic [LANES*LANE_W-1:0]        rb_i,
  input  logic [LANES*LANE_W-1:0]        rc_i,
  input  logic [9:0]                     imm10_i,
  input  logic [RT_W-1:0]                addr_rt_i,
  output logic                           in_ready_o,
  output logic [LANES*LANE_W+4+RT_W-1:0] out_pkt_o,
  output logic                           out_valid_o,
  output logic [LATENCY*(1+RT_W)-1:0]    stage_rt_o
);

  localparam int HW = LANE_W / 2;
  localparam int DW = LANES * LANE_W;
  localparam int PW = DW + 4 + RT_W;
  localparam int SW = 1 + RT_W;

  logic          issueAccept;
  logic          issueLegal;
  logic [DW-1:0] issueData;
  logic [PW-1:0] issuePkt;
  logic [PW-1:0] stagePkt_q [LATENCY];
  logic [PW-1:0] stagePkt_d [LATENCY];

  // One lane of the multiplier. All products are formed modulo 2^LANE_W, which is exact for
  // the truncated results; the signed HWxHW product always fits in LANE_W bits, so its top
  // bit is the true sign used by the arithmetic shift of MPYS.
  function automatic logic [LANE_W-1:0] laneResult(
    input logic [2:0]        op,
    input logic [LANE_W-1:0] a,
    input logic [LANE_W-1:0] b,
    input logic [LANE_W-1:0] c,
    input logic [9:0]        imm
  );
    logic [LANE_W-1:0] aL, aH, bL, immX, prodS, prodU, prodH, prodI;
    aL    = LANE_W'(signed'(a[HW-1:0]));
    aH    = LANE_W'(signed'(a[LANE_W-1:HW]));
    bL    = LANE_W'(signed'(b[HW-1:0]));
    immX  = LANE_W'(signed'(imm));
    prodS = aL * bL;
    prodU = LANE_W'(a[HW-1:0]) * LANE_W'(b[HW-1:0]);
    prodH = aH * bL;
    prodI = aL * immX;
    case (op)
      3'd0:    return prodS;
      3'd1:    return prodU;
      3'd2:    return prodH << HW;
      3'd3:    return prodI;
      3'd4:    return prodS + c;
      3'd5:    return LANE_W'(signed'(prodS[LANE_W-1:HW]));
      default: return '0;
    endcase
  endfunction

  assign in_ready_o  = !stall_i;
  assign issueAccept = in_valid_i && !stall_i && !flush_i;
  assign issueLegal  = (op_i <= 3'd5);

  // Compute every lane's result at issue time so the later stages are pure delay.
  always_comb begin
    issueData = '0;
    for (int i = 0; i < LANES; i++) begin
      issueData[(LANES-1-i)*LANE_W +: LANE_W] =
        laneResult(op_i, ra_i[(LANES-1-i)*LANE_W +: LANE_W], rb_i[(LANES-1-i)*LANE_W +: LANE_W],
                   rc_i[(LANES-1-i)*LANE_W +: LANE_W], imm10_i);
    end
  end

  // Illegal ops still take a slot, but as an all-zero packet they look exactly like a bubble.
  always_comb begin
    issuePkt = '0;
    if (issueAccept && issueLegal) begin
      issuePkt = {issueData, 3'(UNIT_ID), 1'b1, addr_rt_i};
    end
  end

  // Next stage contents: stall holds everything, flush then zeroes the youngest stages
  // regardless of stall so a killed op can never resume.
  always_comb begin
    for (int s = 0; s < LATENCY; s++) begin
      stagePkt_d[s] = stagePkt_q[s];
    end
    if (!stall_i) begin
      stagePkt_d[0] = issuePkt;
      for (int s = 1; s < LATENCY; s++) begin
        stagePkt_d[s] = stagePkt_q[s-1];
      end
    end
    if (flush_i) begin
      for (int s = 0; s < FLUSH_DEPTH; s++) begin
        stagePkt_d[s] = '0;
      end
    end
  end

  // Stage registers; reset wins over stall and flush and discards everything in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int s = 0; s < LATENCY; s++) begin
        stagePkt_q[s] <= '0;
      end
    end else begin
      stagePkt_q <= stagePkt_d;
    end
  end

  // Scoreboard view: {we, rt} of each stage, stage 1 in the most significant slot.
  always_comb begin
    stage_rt_o = '0;
    for (int s = 0; s < LATENCY; s++) begin
      stage_rt_o[(LATENCY-1-s)*SW +: SW] = stagePkt_q[s][SW-1:0];
    end
  end

  assign out_pkt_o   = stagePkt_q[LATENCY-1];
  assign out_valid_o = stagePkt_q[LATENCY-1][RT_W];

endmodule
